// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional single-cycle multiply path is enabled by the MDU_FAST_MULT_EN macro.
package mdu_pkg;

    localparam int WIDTH       = 32;
    localparam int MDU_LATENCY = 33;
    localparam int CNT_W       = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = '1;

    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Handshake/data bundle between the EX stage and the multiply/divide unit.
import mdu_pkg::*;

interface mdu_if;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             write_hi;
    logic             write_lo;
    logic             cancel;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, operand_a, operand_b, write_hi, write_lo, cancel,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, operand_a, operand_b, write_hi, write_lo, cancel,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_shift_core.sv
// Datapath of the iterative unit: one shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle on unsigned magnitudes.
import mdu_pkg::*;

module mdu_shift_core (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_div;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    // Multiply: r_hi:r_lo is the product accumulator, r_lo doubles as the
    // multiplier shifting out LSB first. Divide: r_hi is the partial
    // remainder, r_lo the dividend shifting out MSB first / quotient in.
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_trial = {r_hi, r_lo[WIDTH-1]};
        w_diff  = {1'b0, w_trial} - {2'b00, r_b};
        w_fits  = ~w_diff[WIDTH+1];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
            r_div <= i_div;
        end else if (i_step) begin
            if (r_div) begin
                r_hi <= w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_fits};
            end else begin
                r_hi <= w_sum[WIDTH:1];
                r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit holding HI/LO, with MTHI/MTLO and flush.
// Define MDU_FAST_MULT_EN to compute multiplies in one cycle (IDLE -> SIGN).
import mdu_pkg::*;

module mult_div_unit (
    input  logic i_clk,
    input  logic i_rst,
    mdu_if.slave bus
);

    state_e           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_raw_a;

    op_e              w_op;
    logic             w_signed;
    logic             w_launch;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_op     = op_e'(bus.op);
    assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_launch = (r_state == IDLE) && bus.start && !bus.cancel;
    assign w_a_mag  = w_signed ? abs_val(bus.operand_a) : bus.operand_a;
    assign w_b_mag  = w_signed ? abs_val(bus.operand_b) : bus.operand_b;

    mdu_shift_core u_core (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_launch),
        .i_step (r_state == CALC),
        .i_div  (w_op[1]),
        .i_a    (w_a_mag),
        .i_b    (w_b_mag),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] r_fast_prod;
    logic [2*WIDTH-1:0] w_fast_prod;

    assign w_fast_prod = w_a_mag * w_b_mag;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fast_prod <= '0;
        end else if (w_launch) begin
            r_fast_prod <= w_fast_prod;
        end
    end

    assign w_prod = r_fast_prod;
`else
    assign w_prod = {w_core_hi, w_core_lo};
`endif

    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quot   = r_neg_q ? -w_core_lo : w_core_lo;
    assign w_rem    = r_neg_r ? -w_core_hi : w_core_hi;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_raw_a  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.write_hi) r_hi <= bus.operand_a;
                    if (bus.write_lo) r_lo <= bus.operand_a;
                    if (w_launch) begin
                        r_is_div <= w_op[1];
                        r_neg_q  <= w_signed && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                        r_neg_r  <= w_signed && bus.operand_a[WIDTH-1];
                        r_div0   <= (bus.operand_b == '0);
                        r_raw_a  <= bus.operand_a;
                        r_count  <= CNT_W'(WIDTH - 1);
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
`ifdef MDU_FAST_MULT_EN
                        if (!w_op[1]) r_state <= SIGN;
`endif
                    end
                end
                CALC: begin
                    if (bus.cancel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_count == '0) begin
                        r_state <= SIGN;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                SIGN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.cancel) begin
                        r_done <= 1'b1;
                        if (!r_is_div) begin
                            r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_s[WIDTH-1:0];
                        end else if (r_div0) begin
                            // Divide by zero: HI keeps the raw dividend.
                            r_hi <= r_raw_a;
                            r_lo <= DIV0_QUOTIENT;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, flush/reset
// interruption, HI/LO writes versus Busy, and random back-to-back operations.
import mdu_pkg::*;

module tb_mult_div_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_if bus();

    mult_div_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    res_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic res_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = '0;
        case (op)
            2'd0: begin p = longint'(sa * sb); r = p; end
            2'd1: begin p = ua * ub; r = p; end
            2'd2: begin
                if (b == 32'h0) begin r.hi = a; r.lo = 32'hFFFFFFFF; end
                else begin sq = sa / sb; sr = sa % sb; r.hi = sr[31:0]; r.lo = sq[31:0]; end
            end
            default: begin
                if (b == 32'h0) begin r.hi = a; r.lo = 32'hFFFFFFFF; end
                else begin p = ua / ub; r.lo = p[31:0]; p = ua % ub; r.hi = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] op);
`ifdef MDU_FAST_MULT_EN
        if (!op[1]) return 1;
`endif
        return MDU_LATENCY;
    endfunction

    // Drives Start so it is sampled at the next rising edge (E0); returns at E0+1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input res_t exp_r, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        if (push) sb_q.push_back(exp_r);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic write_regs(input logic [31:0] hi_v, input logic [31:0] lo_v);
        @(negedge clk);
        bus.write_hi = 1'b1;
        bus.operand_a = hi_v;
        @(posedge clk);
        #1;
        bus.write_hi = 1'b0;
        @(negedge clk);
        bus.write_lo = 1'b1;
        bus.operand_a = lo_v;
        @(posedge clk);
        #1;
        bus.write_lo = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.op = 0; bus.operand_a = 0; bus.operand_b = 0;
        bus.write_hi = 0; bus.write_lo = 0; bus.cancel = 0;
        rst = 1'b1;
        #12;
        n_vec++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b, need all zero",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: hi=%h lo=%h busy=%b done=%b", bus.hi, bus.lo, bus.busy, bus.done);
    endtask

    task automatic test_directed();
        vec_t tbl[9] = '{
            '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
            '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB},
            '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
            '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
            '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF},
            '{2'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF},
            '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
            '{2'd3, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999},
            '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD}
        };
        int   lat;
        res_t exp_r;
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo}, 1'b1);
            n_vec++;
            if (bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_busy_after_start: got %b need 1", i, bus.busy);
            end
            wait_done(lat);
            exp_r = sb_q.pop_front();
            n_vec++;
            if (lat !== exp_lat(tbl[i].op)) begin
                n_err++;
                $display("FAIL dir%0d_latency: got %0d need %0d", i, lat, exp_lat(tbl[i].op));
            end
            n_vec++;
            if ({bus.hi, bus.lo} !== exp_r || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_result: got hi=%h lo=%h busy=%b need hi=%h lo=%h busy=0",
                         i, bus.hi, bus.lo, bus.busy, exp_r.hi, exp_r.lo);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (bus.done !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_done_width: done still %b one cycle later", i, bus.done);
            end
            $display("op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", tbl[i].op, tbl[i].a, tbl[i].b,
                     exp_r.hi, exp_r.lo, lat);
        end
    endtask

    task automatic test_cancel();
        int seen = 0;
        write_regs(32'd5, 32'd6);
        issue(2'd3, 32'd50, 32'd7, '0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_busy: got %b need 0", bus.busy);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen++;
        end
        n_vec++;
        if (seen != 0 || bus.hi !== 32'd5 || bus.lo !== 32'd6) begin
            n_err++;
            $display("FAIL cancel_hold: got done_pulses=%0d hi=%h lo=%h need 0, 5, 6", seen, bus.hi, bus.lo);
        end
        $display("cancel at E10: busy=%b hi=%h lo=%h done_pulses=%0d", bus.busy, bus.hi, bus.lo, seen);
    endtask

    task automatic test_reset_mid();
        write_regs(32'd5, 32'd6);
        issue(2'd3, 32'd50, 32'd7, '0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b need 0 0 0", bus.hi, bus.lo, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-op: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    endtask

    task automatic test_write_busy();
        int   lat;
        res_t exp_r;
        write_regs(32'h0000AAAA, 32'h0000BBBB);
        issue(2'd3, 32'd1000, 32'd7, '{hi: 32'd6, lo: 32'd142}, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.write_hi = 1'b1;
        bus.start = 1'b1;
        bus.op = 2'd3;
        bus.operand_a = 32'h1234;
        bus.operand_b = 32'd1;
        @(posedge clk);
        #1;
        bus.write_hi = 1'b0;
        bus.start = 1'b0;
        n_vec++;
        if (bus.hi !== 32'h0000AAAA || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL write_while_busy: got hi=%h busy=%b need hi=0000aaaa busy=1", bus.hi, bus.busy);
        end
        wait_done(lat);
        exp_r = sb_q.pop_front();
        n_vec++;
        if (lat < 0 || {bus.hi, bus.lo} !== exp_r) begin
            n_err++;
            $display("FAIL busy_write_result: got hi=%h lo=%h (lat %0d) need hi=%h lo=%h",
                     bus.hi, bus.lo, lat, exp_r.hi, exp_r.lo);
        end
        $display("write while busy: hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_write_idle();
        int   lat;
        res_t exp_r;
        @(negedge clk);
        bus.write_hi = 1'b1;
        bus.operand_a = 32'h1234;
        @(posedge clk);
        #1;
        bus.write_hi = 1'b0;
        n_vec++;
        if (bus.hi !== 32'h1234 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL write_idle: got hi=%h done=%b need hi=00001234 done=0", bus.hi, bus.done);
        end
        // MTLO coinciding with Start: write lands, then the result overwrites it.
        @(negedge clk);
        bus.write_lo = 1'b1;
        bus.start = 1'b1;
        bus.op = 2'd3;
        bus.operand_a = 32'h0000BEEF;
        bus.operand_b = 32'h10;
        sb_q.push_back('{hi: 32'hF, lo: 32'hBEE});
        @(posedge clk);
        #1;
        bus.write_lo = 1'b0;
        bus.start = 1'b0;
        n_vec++;
        if (bus.lo !== 32'h0000BEEF || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL write_and_start: got lo=%h busy=%b need lo=0000beef busy=1", bus.lo, bus.busy);
        end
        wait_done(lat);
        exp_r = sb_q.pop_front();
        n_vec++;
        if (lat !== MDU_LATENCY || {bus.hi, bus.lo} !== exp_r) begin
            n_err++;
            $display("FAIL write_start_result: got hi=%h lo=%h lat=%0d need hi=%h lo=%h lat=%0d",
                     bus.hi, bus.lo, lat, exp_r.hi, exp_r.lo, MDU_LATENCY);
        end
        $display("write idle + start: hi=%h lo=%h", bus.hi, bus.lo);
    endtask

    task automatic test_back_to_back();
        int          lat;
        res_t        exp_r;
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 3) ? 32'h0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            issue(op, a, b, model(op, a, b), 1'b1);
            wait_done(lat);
            exp_r = sb_q.pop_front();
            n_vec++;
            if (lat !== exp_lat(op) || {bus.hi, bus.lo} !== exp_r) begin
                n_err++;
                $display("FAIL b2b%0d: op=%0d a=%h b=%h got hi=%h lo=%h lat=%0d need hi=%h lo=%h lat=%0d",
                         i, op, a, b, bus.hi, bus.lo, lat, exp_r.hi, exp_r.lo, exp_lat(op));
            end
            $display("b2b op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, bus.hi, bus.lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_cancel();
        test_reset_mid();
        test_write_busy();
        test_write_idle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
